// File: rtl/cpu_arb_pkg.sv
// Shared types for the CPU fetch/data memory arbiter.
package cpu_arb_pkg;

  localparam int CPU_AW           = 16;
  localparam int CPU_DW           = 16;
  localparam int CPU_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_D} owner_t;
  typedef enum logic {S_IDLE, S_HOLD} state_t;

  typedef struct packed {
    logic [CPU_AW-1:0] addr;
    logic [CPU_DW-1:0] wdata;
    logic              rd;
    logic              wr;
  } cmd_t;

endpackage

// File: rtl/cpu_arb_starve_ctr.sv
// Fetch starvation guard: down-counts lost arbitration cycles, flags force at zero.
module cpu_arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_lost,
  input  logic i_clear,
  output logic o_force
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      cnt_q <= CW'(LIMIT);
    end else if (i_lost && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign o_force = (cnt_q == '0);

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data ld/st.
// Optional fetch starvation guard enabled by CPU_ARB_STARVE_GUARD_EN.
//
// state  | meaning
// S_IDLE | arbitrate combinationally, drive winner's command this cycle
// S_HOLD | memory stalled; latched owner/command held until accepted
module cpu_mem_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int AW = CPU_AW,
  parameter int DW = CPU_DW
`ifdef CPU_ARB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = CPU_STARVE_LIMIT
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_f_req,
  input  logic [AW-1:0] i_f_addr,
  output logic          o_f_gnt,
  output logic          o_f_valid,
  output logic [DW-1:0] o_f_rdata,
  input  logic          i_d_rd,
  input  logic          i_d_wr,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_d_gnt,
  output logic          o_d_valid,
  output logic [DW-1:0] o_d_rdata,
  output logic [AW-1:0] o_m_addr,
  output logic [DW-1:0] o_m_wdata,
  output logic          o_m_rd,
  output logic          o_m_wr,
  input  logic          i_m_wait,
  input  logic [DW-1:0] i_m_rdata
);

  state_t state_q;
  owner_t owner_q;
  cmd_t   cmd_q;
  logic   f_tag_q;
  logic   d_tag_q;

  owner_t owner;
  cmd_t   cmd;
  logic   accept;
  logic   force_f;
  logic   d_req;

  assign d_req = i_d_rd | i_d_wr;

`ifdef CPU_ARB_STARVE_GUARD_EN
  logic f_lost;
  assign f_lost = i_f_req && (owner == OWN_D);

  cpu_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve_ctr (
    .clk     (clk),
    .reset   (reset),
    .i_lost  (f_lost),
    .i_clear (o_f_gnt),
    .o_force (force_f)
  );
`else
  assign force_f = 1'b0;
`endif

  always_comb begin
    owner = OWN_NONE;
    cmd   = '0;
    if (state_q == S_HOLD) begin
      owner = owner_q;
      cmd   = cmd_q;
    end else if (i_f_req && (force_f || !d_req)) begin
      owner    = OWN_F;
      cmd.addr = i_f_addr;
      cmd.rd   = 1'b1;
    end else if (d_req) begin
      // A simultaneous rd+wr is treated as a store.
      owner     = OWN_D;
      cmd.addr  = i_d_addr;
      cmd.wr    = i_d_wr;
      cmd.rd    = !i_d_wr;
      cmd.wdata = i_d_wr ? i_d_wdata : '0;
    end
  end

  assign accept    = (cmd.rd || cmd.wr) && !i_m_wait;
  assign o_f_gnt   = accept && (owner == OWN_F);
  assign o_d_gnt   = accept && (owner == OWN_D);
  assign o_m_addr  = cmd.addr;
  assign o_m_wdata = cmd.wdata;
  assign o_m_rd    = cmd.rd;
  assign o_m_wr    = cmd.wr;
  assign o_f_valid = f_tag_q;
  assign o_d_valid = d_tag_q;
  assign o_f_rdata = f_tag_q ? i_m_rdata : '0;
  assign o_d_rdata = d_tag_q ? i_m_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= OWN_NONE;
      cmd_q   <= '0;
      f_tag_q <= 1'b0;
      d_tag_q <= 1'b0;
    end else begin
      f_tag_q <= o_f_gnt;
      d_tag_q <= o_d_gnt && cmd.rd;
      case (state_q)
        S_IDLE: begin
          if (owner != OWN_NONE && !accept) begin
            state_q <= S_HOLD;
            owner_q <= owner;
            cmd_q   <= cmd;
          end
        end
        S_HOLD: begin
          if (accept) begin
            state_q <= S_IDLE;
            owner_q <= OWN_NONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(i_d_rd && i_d_wr))
        else $warning("cpu_mem_arbiter: data rd and wr requested together, store wins");
      assert (!(state_q == S_HOLD &&
                ((owner_q == OWN_F && !i_f_req) || (owner_q == OWN_D && !d_req))))
        else $warning("cpu_mem_arbiter: request withdrawn while command held");
    end
  end
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter with a transaction-level memory/return model.
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_f_req;
  logic [15:0] i_f_addr;
  logic        o_f_gnt, o_f_valid;
  logic [15:0] o_f_rdata;
  logic        i_d_rd, i_d_wr;
  logic [15:0] i_d_addr, i_d_wdata;
  logic        o_d_gnt, o_d_valid;
  logic [15:0] o_d_rdata;
  logic [15:0] o_m_addr, o_m_wdata;
  logic        o_m_rd, o_m_wr;
  logic        i_m_wait;
  logic [15:0] i_m_rdata;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:1023];

  cpu_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_f_req(i_f_req), .i_f_addr(i_f_addr), .o_f_gnt(o_f_gnt),
    .o_f_valid(o_f_valid), .o_f_rdata(o_f_rdata),
    .i_d_rd(i_d_rd), .i_d_wr(i_d_wr), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_gnt(o_d_gnt), .o_d_valid(o_d_valid), .o_d_rdata(o_d_rdata),
    .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata), .o_m_rd(o_m_rd), .o_m_wr(o_m_wr),
    .i_m_wait(i_m_wait), .i_m_rdata(i_m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: every accepted read must come back next cycle with the
  // memory contents at acceptance time; writes update the model memory.
  logic        exp_fv = 1'b0, exp_dv = 1'b0;
  logic [15:0] exp_fd = '0, exp_dd = '0;
  logic        ret_pend = 1'b0;
  logic [15:0] ret_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      exp_fv   = 1'b0;
      exp_dv   = 1'b0;
      ret_pend = 1'b0;
    end else begin
      chk("f_valid", 64'(o_f_valid), 64'(exp_fv));
      chk("f_rdata", 64'(o_f_rdata), exp_fv ? 64'(exp_fd) : 64'h0);
      chk("d_valid", 64'(o_d_valid), 64'(exp_dv));
      chk("d_rdata", 64'(o_d_rdata), exp_dv ? 64'(exp_dd) : 64'h0);
      chk("m_rd_wr_excl", 64'(o_m_rd & o_m_wr), 64'h0);
      chk("single_gnt", 64'(o_f_gnt & o_d_gnt), 64'h0);
      chk("f_gnt_needs_req", 64'(o_f_gnt & !i_f_req), 64'h0);
      chk("d_gnt_needs_req", 64'(o_d_gnt & !(i_d_rd | i_d_wr)), 64'h0);
      exp_fv   = 1'b0;
      exp_dv   = 1'b0;
      ret_pend = 1'b0;
      if (o_f_gnt) begin
        chk("f_cmd", 64'({o_m_rd, o_m_wr, o_m_addr}), 64'({2'b10, i_f_addr}));
        exp_fv   = 1'b1;
        exp_fd   = mem[i_f_addr[9:0]];
        ret_pend = 1'b1;
        ret_data = exp_fd;
      end
      if (o_d_gnt) begin
        if (i_d_wr) begin
          chk("d_wr_cmd", 64'({o_m_rd, o_m_wr, o_m_addr, o_m_wdata}),
              64'({2'b01, i_d_addr, i_d_wdata}));
          mem[i_d_addr[9:0]] = i_d_wdata;
        end else begin
          chk("d_rd_cmd", 64'({o_m_rd, o_m_wr, o_m_addr, o_m_wdata}),
              64'({2'b10, i_d_addr, 16'h0000}));
          exp_dv   = 1'b1;
          exp_dd   = mem[i_d_addr[9:0]];
          ret_pend = 1'b1;
          ret_data = exp_dd;
        end
      end
    end
  end

  // Memory read port: data returns the cycle after acceptance, junk otherwise.
  always @(posedge clk) begin
    #1;
    i_m_rdata = ret_pend ? ret_data : 16'hA5A5;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{o_f_gnt, o_f_valid, o_f_rdata, o_d_gnt, o_d_valid, o_d_rdata,
             o_m_addr, o_m_wdata, o_m_rd, o_m_wr};
  endfunction

  int gnt_at;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'h5A00;
    reset = 1'b1; i_f_req = 0; i_f_addr = '0; i_d_rd = 0; i_d_wr = 0;
    i_d_addr = '0; i_d_wdata = '0; i_m_wait = 0; i_m_rdata = '0;
    next_cycle();
    @(negedge clk);
    chk("reset_outs_zero", 64'(any_out()), 64'h0);
    next_cycle();
    reset = 1'b0;

    // 1: lone fetch
    i_f_req = 1; i_f_addr = 16'h0010;
    @(negedge clk);
    chk("t1_f_gnt", 64'({o_f_gnt, o_m_rd, o_m_addr}), 64'({2'b11, 16'h0010}));
    next_cycle();
    i_f_req = 0;
    @(negedge clk);
    chk("t1_f_ret", 64'({o_f_valid, o_f_rdata}), 64'({1'b1, 16'h5A10}));

    // 2: fetch and load collide; data first
    next_cycle();
    i_f_req = 1; i_f_addr = 16'h0020; i_d_rd = 1; i_d_addr = 16'h0200;
    @(negedge clk);
    chk("t2_d_first", 64'({o_d_gnt, o_f_gnt}), 64'b10);
    next_cycle();
    i_d_rd = 0;
    @(negedge clk);
    chk("t2_f_second", 64'({o_f_gnt, o_d_valid, o_d_rdata}), 64'({2'b11, 16'h5800}));
    next_cycle();
    i_f_req = 0;
    @(negedge clk);
    chk("t2_f_ret", 64'({o_f_valid, o_d_valid, o_f_rdata}), 64'({2'b10, 16'h5A20}));

    // 3: fetch stalled 3 cycles, store arrives during the hold
    next_cycle();
    i_f_req = 1; i_f_addr = 16'h0040; i_m_wait = 1;
    @(negedge clk);
    chk("t3_c1", 64'({o_f_gnt, o_m_rd, o_m_wr, o_m_addr}), 64'({3'b010, 16'h0040}));
    for (int c = 2; c <= 3; c++) begin
      next_cycle();
      i_d_wr = 1; i_d_addr = 16'h0300; i_d_wdata = 16'hBEEF;
      @(negedge clk);
      chk("t3_hold", 64'({o_f_gnt, o_d_gnt, o_m_rd, o_m_wr, o_m_addr}),
          64'({4'b0010, 16'h0040}));
    end
    next_cycle();
    i_m_wait = 0;
    @(negedge clk);
    chk("t3_f_gnt_c4", 64'({o_f_gnt, o_d_gnt, o_m_addr}), 64'({2'b10, 16'h0040}));
    next_cycle();
    i_f_req = 0;
    @(negedge clk);
    chk("t3_st_c5", 64'({o_d_gnt, o_m_wr, o_m_wdata, o_m_addr, o_f_valid}),
        64'({2'b11, 16'hBEEF, 16'h0300, 1'b1}));
    next_cycle();
    i_d_wr = 0; i_d_wdata = '0; i_d_rd = 1;
    @(negedge clk);
    chk("t3_no_d_valid", 64'(o_d_valid), 64'h0);
    next_cycle();
    i_d_rd = 0;
    @(negedge clk);
    chk("t3_readback", 64'({o_d_valid, o_d_rdata}), 64'({1'b1, 16'hBEEF}));

    // 4: reset during a held load
    next_cycle();
    i_d_rd = 1; i_d_addr = 16'h0100; i_m_wait = 1;
    @(negedge clk);
    chk("t4_held", 64'({o_m_rd, o_d_gnt}), 64'b10);
    next_cycle();
    reset = 1; i_d_rd = 0; i_m_wait = 0;
    next_cycle();
    @(negedge clk);
    chk("t4_outs_zero", 64'(any_out()), 64'h0);
    next_cycle();
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_no_valid", 64'(o_d_valid), 64'h0);
      next_cycle();
    end

    // 5: continuous data traffic against a waiting fetch
    i_f_req = 1; i_f_addr = 16'h0050; i_d_rd = 1;
    gnt_at = -1;
    for (int k = 0; k < 10; k++) begin
      i_d_addr = 16'h0180 + 16'(k);
      @(negedge clk);
      if (o_f_gnt && gnt_at < 0) gnt_at = k;
      next_cycle();
      if (gnt_at >= 0) i_f_req = 0;
    end
`ifdef CPU_ARB_STARVE_GUARD_EN
    chk("t5_gnt_after_4", 64'(gnt_at), 64'(4));
`else
    chk("t5_never_gnt", 64'(gnt_at), 64'(-1));
`endif
    i_d_rd = 0;
    @(negedge clk);
`ifdef CPU_ARB_STARVE_GUARD_EN
    chk("t5_idle_after", 64'(o_f_gnt), 64'h0);
`else
    chk("t5_gnt_when_data_stops", 64'(o_f_gnt), 64'h1);
`endif
    next_cycle();
    i_f_req = 0;

    // 6: illegal rd+wr, store wins
    i_d_rd = 1; i_d_wr = 1; i_d_addr = 16'h0310; i_d_wdata = 16'h1234;
    @(negedge clk);
    chk("t6_wr_wins", 64'({o_d_gnt, o_m_rd, o_m_wr, o_m_wdata}), 64'({3'b101, 16'h1234}));
    next_cycle();
    i_d_rd = 0; i_d_wr = 0; i_d_wdata = '0;
    @(negedge clk);
    chk("t6_no_valid", 64'(o_d_valid), 64'h0);
    next_cycle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
